// File: rtl/truth_table_sweeper.sv
// Purpose: steps {A,B,C} through all 8 vectors, captures y into an 8-bit truth table, compares it to EXPECTED.
// Latency: each vector is held SETTLE cycles; busy lasts 8*SETTLE cycles; done rises on the edge capturing vector 7.
// Backpressure: none; start is taken only in IDLE/DONE, start during a sweep is dropped, abort cancels a sweep.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          sweep request / synchronous cancel (abort wins over start)
//   A, B, C               registered stimulus, {A,B,C} = vector index
//   y                     combinational response of the function under test
//   busy, done            sweep running / sweep completed (level, held until next accepted start)
//   table_out             captured truth table, bit i = y at {A,B,C}=i
//   match, mismatch_mask  comparison against EXPECTED, qualified by done
module truth_table_sweeper #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [7:0]  EXPECTED = 8'h32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [7:0] mismatch_mask
);

    localparam int WAIT_W = $clog2(SETTLE + 1);
    // Last wait count of a vector; y is sampled on this cycle's edge.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [2:0]          idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [2:0]          abc;

    assign {A, B, C} = abc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            abc       <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= 8'h00;
            idx       <= 3'd0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // start+abort together leaves everything untouched
                    if (start && !abort) begin
                        state     <= SWEEP;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        table_out <= 8'h00;
                        idx       <= 3'd0;
                        wait_cnt  <= '0;
                        abc       <= 3'b000;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        // partial table is kept; uncaptured bits were cleared at start
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        abc      <= 3'b000;
                        idx      <= 3'd0;
                        wait_cnt <= '0;
                    end else if (wait_cnt != WAIT_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        table_out[idx] <= y;
                        wait_cnt       <= '0;
                        if (idx == 3'd7) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            abc   <= 3'b000;
                            idx   <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                            abc <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    abc   <= 3'b000;
                end
            endcase
        end
    end

    // Qualified by done so a partial or aborted table never reports a result.
    assign match         = done && (table_out == EXPECTED);
    assign mismatch_mask = done ? (table_out ^ EXPECTED) : 8'h00;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: self-checking bench for truth_table_sweeper, two instances (SETTLE=2/8'h32 and SETTLE=1/8'h8E).
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle from the active edge.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_truth_table_sweeper;

    logic clk;
    logic rst_n;

    // instance 0: SETTLE=2, EXPECTED=8'h32
    logic       start0, abort0, y0;
    logic       A0, B0, C0, busy0, done0, match0;
    logic [7:0] tbl0, mask0;
    // instance 1: SETTLE=1, EXPECTED=8'h8E
    logic       start1, abort1, y1;
    logic       A1, B1, C1, busy1, done1, match1;
    logic [7:0] tbl1, mask1;

    // y source select: 0 canonical formula, 1 stuck-at-0 (inst 0 only), 2 random table
    int         mode0, mode1;
    logic [7:0] tt0, tt1;

    int checks;
    int errors;

    truth_table_sweeper #(.SETTLE(2), .EXPECTED(8'h32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .A(A0), .B(B0), .C(C0), .y(y0), .busy(busy0), .done(done0),
        .table_out(tbl0), .match(match0), .mismatch_mask(mask0)
    );

    truth_table_sweeper #(.SETTLE(1), .EXPECTED(8'h8E)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .A(A1), .B(B1), .C(C1), .y(y1), .busy(busy1), .done(done1),
        .table_out(tbl1), .match(match1), .mismatch_mask(mask1)
    );

    // Functions under test, written straight from their Boolean form.
    always_comb begin
        y0 = 1'b0;
        if (mode0 == 0)      y0 = ~B0 & (A0 | C0);
        else if (mode0 == 2) y0 = tt0[{A0, B0, C0}];
        y1 = 1'b0;
        if (mode1 == 0) y1 = (B1 & C1) | (~A1 & (B1 ^ C1));
        else            y1 = tt1[{A1, B1, C1}];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] abc_of(input int w);
        return (w != 0) ? {A1, B1, C1} : {A0, B0, C0};
    endfunction
    function automatic logic busy_of(input int w);
        return (w != 0) ? busy1 : busy0;
    endfunction
    function automatic logic done_of(input int w);
        return (w != 0) ? done1 : done0;
    endfunction
    function automatic logic match_of(input int w);
        return (w != 0) ? match1 : match0;
    endfunction
    function automatic logic [7:0] tbl_of(input int w);
        return (w != 0) ? tbl1 : tbl0;
    endfunction
    function automatic logic [7:0] mask_of(input int w);
        return (w != 0) ? mask1 : mask0;
    endfunction

    task automatic drive(input int w, input logic s, input logic a);
        if (w != 0) begin start1 = s; abort1 = a; end
        else        begin start0 = s; abort0 = a; end
    endtask

    // One sweep from IDLE/DONE. full = truth table of the current y source.
    // abort_at > 0 aborts during that busy cycle; start_at > 0 pulses start during that busy cycle.
    task automatic run_sweep(input int w, input logic [7:0] full, input int abort_at, input int start_at);
        int         s;
        int         cyc;
        int         nvec;
        logic [7:0] expv;
        logic [7:0] keep;
        s    = (w != 0) ? 1 : 2;
        expv = (w != 0) ? 8'h8E : 8'h32;
        @(negedge clk);
        drive(w, 1'b1, 1'b0);
        @(negedge clk);
        drive(w, 1'b0, 1'b0);
        check("done_low_after_start", {31'd0, done_of(w)}, 32'd0);
        check("match_low_in_sweep", {31'd0, match_of(w)}, 32'd0);
        cyc = 0;
        while (busy_of(w) && cyc < 100) begin
            cyc++;
            check("abc_step", {29'd0, abc_of(w)}, 32'((cyc - 1) / s));
            drive(w, (cyc == start_at), (cyc == abort_at));
            @(negedge clk);
            drive(w, 1'b0, 1'b0);
        end
        check("abc_idle", {29'd0, abc_of(w)}, 32'd0);
        check("busy_end", {31'd0, busy_of(w)}, 32'd0);
        if (abort_at > 0) begin
            nvec = (abort_at - 1) / s;
            keep = 8'((1 << nvec) - 1);
            check("abort_len", cyc, abort_at);
            check("abort_done", {31'd0, done_of(w)}, 32'd0);
            check("abort_table", {24'd0, tbl_of(w)}, {24'd0, full & keep});
            check("abort_match", {31'd0, match_of(w)}, 32'd0);
            check("abort_mask", {24'd0, mask_of(w)}, 32'd0);
        end else begin
            check("sweep_len", cyc, 8 * s);
            check("done_set", {31'd0, done_of(w)}, 32'd1);
            check("table", {24'd0, tbl_of(w)}, {24'd0, full});
            check("match", {31'd0, match_of(w)}, {31'd0, full == expv});
            check("mask", {24'd0, mask_of(w)}, {24'd0, full ^ expv});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_0"}, {busy0, done0, A0, B0, C0, match0, tbl0, mask0}, 22'd0);
        check({tag, "_1"}, {busy1, done1, A1, B1, C1, match1, tbl1, mask1}, 22'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int s;
        int cyc;
        int ab;
        int st;
        logic [7:0] prev;

        checks = 0;
        errors = 0;
        mode0 = 0; mode1 = 0; tt0 = 8'h00; tt1 = 8'h00;
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
        rst_n = 0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // start+abort in IDLE: nothing happens
        drive(0, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0);
        check("idle_start_abort_busy", {31'd0, busy0}, 32'd0);
        check("idle_start_abort_done", {31'd0, done0}, 32'd0);

        // canonical functions
        run_sweep(0, 8'h32, 0, 0);
        run_sweep(1, 8'h8E, 0, 0);

        // start+abort in DONE: stays DONE with table intact
        drive(0, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0);
        check("done_start_abort_done", {31'd0, done0}, 32'd1);
        check("done_start_abort_table", {24'd0, tbl0}, 32'h32);

        // stuck-at-0 output
        mode0 = 1;
        run_sweep(0, 8'h00, 0, 0);
        mode0 = 0;

        // abort in vector 2, then clean restart; then start during a sweep
        run_sweep(0, 8'h32, 5, 0);
        run_sweep(0, 8'h32, 0, 0);
        run_sweep(0, 8'h32, 0, 6);

        // asynchronous reset while vector 5 is presented
        @(negedge clk);
        drive(0, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0);
        cyc = 0;
        while ({A0, B0, C0} != 3'd5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_vec5", {29'd0, A0, B0, C0}, 32'd5);
        #1 rst_n = 0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1;
        run_sweep(0, 8'h32, 0, 0);

        // randomized functions, abort points and stray starts
        for (int i = 0; i < 24; i++) begin
            w  = int'($urandom_range(0, 1));
            s  = (w != 0) ? 1 : 2;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8 * s - 1)) : 0;
            st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8 * s - 1)) : 0;
            if (ab != 0 && st >= ab) st = 0;
            if (w != 0) begin
                tt1 = 8'($urandom); mode1 = 2;
                run_sweep(1, tt1, ab, st);
            end else begin
                tt0 = 8'($urandom); mode0 = 2;
                run_sweep(0, tt0, ab, st);
            end
            // abort outside a sweep must not disturb the result
            prev = tbl_of(w);
            drive(w, 1'b0, 1'b1);
            @(negedge clk);
            drive(w, 1'b0, 1'b0);
            check("abort_noop_table", {24'd0, tbl_of(w)}, {24'd0, prev});
            check("abort_noop_done", {31'd0, done_of(w)}, {31'd0, ab == 0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
